// File: rtl/game_round_ctrl_pkg.sv
// Shared definitions for the game round sequencer: state encoding, default widths and scoring.
package game_round_ctrl_pkg;

   localparam int unsigned DefTimeW  = 5;
   localparam int unsigned DefScoreW = 8;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StArm   = 3'd1,
      StPlay  = 3'd2,
      StScore = 3'd3,
      StNext  = 3'd4,
      StDone  = 3'd5
   } state_e;

   // A wrong answer scores nothing; a fast correct answer earns one bonus point.
   function automatic logic [1:0] calc_pts(input logic correct, input logic bonus);
      if (!correct) return 2'd0;
      return bonus ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Front-panel and timer signals of the round sequencer; slave is the sequencer side.
interface game_round_ctrl_if
   import game_round_ctrl_pkg::*;
#(
   parameter int unsigned TIME_W  = DefTimeW,
   parameter int unsigned SCORE_W = DefScoreW
);

   logic               btn_start;
   logic               answer_valid;
   logic               answer_correct;
   logic [TIME_W-1:0]  time_display;
   logic               time_signal;
   logic               timer_start;
   logic [SCORE_W-1:0] score;
   logic [3:0]         round_num;
   logic               round_active;
   logic               game_over;

   modport master (
      output btn_start, answer_valid, answer_correct, time_display, time_signal,
      input  timer_start, score, round_num, round_active, game_over
   );

   modport slave (
      input  btn_start, answer_valid, answer_correct, time_display, time_signal,
      output timer_start, score, round_num, round_active, game_over
   );

endinterface

// File: rtl/game_round_ctrl_rise_detect.sv
// Registered rising-edge detector for an already-synchronised button level.
module game_round_ctrl_rise_detect (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_din,
   output logic o_rise
);

   logic r_din;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_din <= 1'b0;
      end else begin
         r_din <= i_din;
      end
   end

   assign o_rise = i_din & ~r_din;

endmodule

// File: rtl/game_round_ctrl.sv
// Round sequencer around time_counter: arms the timer, ends rounds on answer or expiry,
// accumulates a saturating score with a fast-answer bonus.
module game_round_ctrl
   import game_round_ctrl_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS   = 10,
   parameter int unsigned TIME_W       = DefTimeW,
   parameter int unsigned SCORE_W      = DefScoreW,
   parameter int unsigned BONUS_THRESH = 10
) (
   input logic               i_clk,
   input logic               i_reset,
   game_round_ctrl_if.slave  bus
);

   state_e             r_state;
   logic               r_timer_start;
   logic               r_round_active;
   logic               r_game_over;
   logic [SCORE_W-1:0] r_score;
   logic [3:0]         r_round_num;
   logic               r_armed;
   logic [1:0]         r_pts;

   logic               w_start_rise;
   logic [TIME_W-1:0]  w_time_display;
   logic               w_bonus;
   logic               w_last;
   logic               w_round_end;
   logic [SCORE_W:0]   w_sum;
   logic [SCORE_W-1:0] w_score_sat;

   game_round_ctrl_rise_detect u_start_rise (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_din   (bus.btn_start),
      .o_rise  (w_start_rise)
   );

   assign w_time_display = bus.time_display;
   assign w_bonus        = 32'(w_time_display) >= BONUS_THRESH;
   assign w_last         = r_round_num == 4'(NUM_ROUNDS);
   // Expiry only counts once the timer has been seen running this round.
   assign w_round_end    = bus.answer_valid | (r_armed & bus.time_signal);
   assign w_sum          = {1'b0, r_score} + (SCORE_W + 1)'(r_pts);
   assign w_score_sat    = w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state        <= StIdle;
         r_timer_start  <= 1'b0;
         r_round_active <= 1'b0;
         r_game_over    <= 1'b0;
      end else begin
         r_timer_start <= 1'b0;
         case (r_state)
            StIdle: begin
               if (w_start_rise) begin
                  r_state       <= StArm;
                  r_timer_start <= 1'b1;
               end
            end
            StArm: begin
               r_state        <= StPlay;
               r_round_active <= 1'b1;
            end
            StPlay: begin
               if (w_round_end) begin
                  r_state        <= StScore;
                  r_round_active <= 1'b0;
               end
            end
            StScore: r_state <= StNext;
            StNext: begin
               if (w_last) begin
                  r_state     <= StDone;
                  r_game_over <= 1'b1;
               end else begin
                  r_state       <= StArm;
                  r_timer_start <= 1'b1;
               end
            end
            StDone: begin
               if (w_start_rise) begin
                  r_state       <= StArm;
                  r_timer_start <= 1'b1;
                  r_game_over   <= 1'b0;
               end
            end
            default: begin
               r_state        <= StIdle;
               r_round_active <= 1'b0;
               r_game_over    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_score     <= '0;
         r_round_num <= '0;
         r_armed     <= 1'b0;
         r_pts       <= '0;
      end else begin
         case (r_state)
            StIdle, StDone: begin
               if (w_start_rise) begin
                  r_score     <= '0;
                  r_round_num <= 4'd1;
               end
            end
            StArm: r_armed <= 1'b0;
            StPlay: begin
               if (!bus.time_signal) r_armed <= 1'b1;
               if (bus.answer_valid) begin
                  r_pts <= calc_pts(bus.answer_correct, w_bonus);
               end else if (r_armed && bus.time_signal) begin
                  r_pts <= '0;
               end
            end
            StScore: r_score <= w_score_sat;
            StNext: begin
               if (!w_last) r_round_num <= r_round_num + 4'd1;
            end
            default: begin
               r_score     <= '0;
               r_round_num <= '0;
               r_armed     <= 1'b0;
            end
         endcase
      end
   end

   assign bus.timer_start  = r_timer_start;
   assign bus.score        = r_score;
   assign bus.round_num    = r_round_num;
   assign bus.round_active = r_round_active;
   assign bus.game_over    = r_game_over;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Bench for game_round_ctrl: 3-round games against a small time_counter model, with a
// second 2-bit-score instance sharing the stimulus to exercise saturation.
module tb_game_round_ctrl;

   localparam int unsigned NumRounds = 3;
   localparam int          Bonus     = 10;
   localparam int unsigned TcLoad    = 2;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0;
   logic       answer_valid = 1'b0;
   logic       answer_correct = 1'b0;
   logic       ts_drv = 1'b0;
   logic [4:0] td_drv = '0;
   logic       use_model = 1'b0;

   // time_counter model: reloads one cycle after its start pulse, one count per 4 clocks
   logic [4:0] tc_cnt = '0;
   logic [1:0] tc_div = '0;
   logic       tc_start_q = 1'b0;

   int ts_count = 0;
   int errors = 0;
   int checks = 0;
   int exp_score_a = 0;
   int exp_score_b = 0;
   int q_a[$];
   int q_b[$];

   game_round_ctrl_if #(.TIME_W(5), .SCORE_W(8)) bus_a ();
   game_round_ctrl_if #(.TIME_W(5), .SCORE_W(2)) bus_b ();

   assign bus_a.btn_start      = btn_start;
   assign bus_a.answer_valid   = answer_valid;
   assign bus_a.answer_correct = answer_correct;
   assign bus_a.time_signal    = use_model ? (tc_cnt == 5'd0) : ts_drv;
   assign bus_a.time_display   = use_model ? tc_cnt : td_drv;
   assign bus_b.btn_start      = btn_start;
   assign bus_b.answer_valid   = answer_valid;
   assign bus_b.answer_correct = answer_correct;
   assign bus_b.time_signal    = use_model ? (tc_cnt == 5'd0) : ts_drv;
   assign bus_b.time_display   = use_model ? tc_cnt : td_drv;

   game_round_ctrl #(
      .NUM_ROUNDS(NumRounds), .TIME_W(5), .SCORE_W(8), .BONUS_THRESH(Bonus)
   ) dut_a (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_a)
   );

   game_round_ctrl #(
      .NUM_ROUNDS(NumRounds), .TIME_W(5), .SCORE_W(2), .BONUS_THRESH(Bonus)
   ) dut_b (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus_b)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      tc_start_q <= bus_a.timer_start;
      if (tc_start_q) begin
         tc_cnt <= 5'(TcLoad);
         tc_div <= '0;
      end else if (tc_cnt != 5'd0) begin
         tc_div <= tc_div + 2'd1;
         if (tc_div == 2'd3) tc_cnt <= tc_cnt - 5'd1;
      end
   end

   always @(posedge clk) begin
      if (bus_a.timer_start === 1'b1) ts_count <= ts_count + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulses one answer and queues the score both instances must show once it is scored.
   task automatic drive_answer(input logic correct, input int td, input logic ts);
      int pts;
      pts = (correct == 1'b0) ? 0 : ((td >= Bonus) ? 2 : 1);
      exp_score_a = (exp_score_a + pts > 255) ? 255 : exp_score_a + pts;
      exp_score_b = (exp_score_b + pts > 3) ? 3 : exp_score_b + pts;
      q_a.push_back(exp_score_a);
      q_b.push_back(exp_score_b);
      td_drv = 5'(td);
      answer_valid = 1'b1;
      answer_correct = correct;
      ts_drv = ts;
      step();
      answer_valid = 1'b0;
      answer_correct = 1'b0;
      ts_drv = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      checks++; if (bus_a.timer_start !== 1'b0) begin errors++;
         $display("FAIL reset_timer_start: got %0b expected 0", bus_a.timer_start); end
      checks++; if (bus_a.score !== 8'd0) begin errors++;
         $display("FAIL reset_score: got %0d expected 0", bus_a.score); end
      checks++; if (bus_a.round_num !== 4'd0) begin errors++;
         $display("FAIL reset_round_num: got %0d expected 0", bus_a.round_num); end
      checks++; if (bus_a.round_active !== 1'b0) begin errors++;
         $display("FAIL reset_round_active: got %0b expected 0", bus_a.round_active); end
      checks++; if (bus_a.game_over !== 1'b0) begin errors++;
         $display("FAIL reset_game_over: got %0b expected 0", bus_a.game_over); end
      reset = 1'b0;
      step();
      checks++; if (bus_a.round_num !== 4'd0 || bus_a.timer_start !== 1'b0) begin errors++;
         $display("FAIL idle_after_reset: got round %0d start %0b expected 0 0",
                  bus_a.round_num, bus_a.timer_start); end
   endtask

   task automatic test_start_hold();
      int base;
      base = ts_count;
      exp_score_a = 0;
      exp_score_b = 0;
      btn_start = 1'b1;
      step();
      checks++; if (bus_a.timer_start !== 1'b1) begin errors++;
         $display("FAIL start_latency: got %0b expected 1", bus_a.timer_start); end
      checks++; if (bus_a.round_num !== 4'd1) begin errors++;
         $display("FAIL start_round_num: got %0d expected 1", bus_a.round_num); end
      step();
      checks++; if (bus_a.timer_start !== 1'b0 || bus_a.round_active !== 1'b1) begin errors++;
         $display("FAIL start_pulse_width: got start %0b active %0b expected 0 1",
                  bus_a.timer_start, bus_a.round_active); end
      repeat (48) step();
      checks++; if (ts_count - base != 1) begin errors++;
         $display("FAIL held_button_pulses: got %0d expected 1", ts_count - base); end
      btn_start = 1'b0;
   endtask

   task automatic test_fast_answer();
      int e;
      drive_answer(1'b1, 15, 1'b0);
      step();
      e = q_a.pop_front();
      void'(q_b.pop_front());
      checks++; if (bus_a.score !== 8'(e)) begin errors++;
         $display("FAIL fast_bonus_score: got %0d expected %0d", bus_a.score, e); end
      step();
      checks++; if (bus_a.timer_start !== 1'b1 || bus_a.round_num !== 4'd2) begin errors++;
         $display("FAIL next_round_start: got start %0b round %0d expected 1 2",
                  bus_a.timer_start, bus_a.round_num); end
   endtask

   task automatic test_slow_and_wrong();
      int e;
      step();
      drive_answer(1'b1, 4, 1'b0);
      step();
      e = q_a.pop_front();
      void'(q_b.pop_front());
      checks++; if (bus_a.score !== 8'(e)) begin errors++;
         $display("FAIL slow_answer_score: got %0d expected %0d", bus_a.score, e); end
      step();
      checks++; if (bus_a.round_num !== 4'd3) begin errors++;
         $display("FAIL round3_num: got %0d expected 3", bus_a.round_num); end
      step();
      drive_answer(1'b0, 15, 1'b0);
      step();
      e = q_a.pop_front();
      void'(q_b.pop_front());
      checks++; if (bus_a.score !== 8'(e)) begin errors++;
         $display("FAIL wrong_answer_score: got %0d expected %0d", bus_a.score, e); end
   endtask

   task automatic test_game_over();
      step();
      checks++; if (bus_a.game_over !== 1'b1 || bus_a.round_num !== 4'd3) begin errors++;
         $display("FAIL game_over: got over %0b round %0d expected 1 3",
                  bus_a.game_over, bus_a.round_num); end
      answer_valid = 1'b1;
      answer_correct = 1'b1;
      td_drv = 5'd15;
      step();
      answer_valid = 1'b0;
      answer_correct = 1'b0;
      repeat (12) step();
      checks++; if (bus_a.score !== 8'(exp_score_a) || bus_a.round_num !== 4'd3) begin errors++;
         $display("FAIL done_holds: got score %0d round %0d expected %0d 3",
                  bus_a.score, bus_a.round_num, exp_score_a); end
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      exp_score_a = 0;
      exp_score_b = 0;
      checks++; if (bus_a.timer_start !== 1'b1 || bus_a.score !== 8'd0
                    || bus_a.round_num !== 4'd1 || bus_a.game_over !== 1'b0) begin errors++;
         $display("FAIL restart: got start %0b score %0d round %0d over %0b expected 1 0 1 0",
                  bus_a.timer_start, bus_a.score, bus_a.round_num, bus_a.game_over); end
   endtask

   task automatic test_timeout();
      int  e;
      bit  found;
      use_model = 1'b1;
      q_a.push_back(exp_score_a);
      q_b.push_back(exp_score_b);
      step();
      step();
      checks++; if (bus_a.round_active !== 1'b1) begin errors++;
         $display("FAIL stale_expiry_ignored: got active %0b expected 1", bus_a.round_active); end
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (bus_a.round_active === 1'b0) begin
            found = 1'b1;
            break;
         end
      end
      checks++; if (!found) begin errors++;
         $display("FAIL timeout_ends_round: got active %0b expected 0", bus_a.round_active); end
      step();
      e = q_a.pop_front();
      void'(q_b.pop_front());
      checks++; if (bus_a.score !== 8'(e)) begin errors++;
         $display("FAIL timeout_score: got %0d expected %0d", bus_a.score, e); end
      step();
      checks++; if (bus_a.timer_start !== 1'b1 || bus_a.round_num !== 4'd2) begin errors++;
         $display("FAIL after_timeout_start: got start %0b round %0d expected 1 2",
                  bus_a.timer_start, bus_a.round_num); end
      use_model = 1'b0;
   endtask

   task automatic test_same_cycle();
      int e;
      btn_start = 1'b1;
      step();
      step();
      btn_start = 1'b0;
      drive_answer(1'b1, 12, 1'b1);
      checks++; if (bus_a.round_active !== 1'b0) begin errors++;
         $display("FAIL same_cycle_end: got active %0b expected 0", bus_a.round_active); end
      step();
      e = q_a.pop_front();
      void'(q_b.pop_front());
      checks++; if (bus_a.score !== 8'(e)) begin errors++;
         $display("FAIL answer_beats_expiry: got %0d expected %0d", bus_a.score, e); end
      step();
      checks++; if (bus_a.timer_start !== 1'b1 || bus_a.round_num !== 4'd3) begin errors++;
         $display("FAIL midgame_btn_ignored: got start %0b round %0d expected 1 3",
                  bus_a.timer_start, bus_a.round_num); end
   endtask

   task automatic test_reset_mid_play();
      int base;
      step();
      step();
      reset = 1'b1;
      step();
      checks++; if (bus_a.score !== 8'd0 || bus_a.round_num !== 4'd0 || bus_a.round_active !== 1'b0
                    || bus_a.timer_start !== 1'b0 || bus_a.game_over !== 1'b0) begin errors++;
         $display("FAIL mid_play_reset: got score %0d round %0d active %0b expected 0 0 0",
                  bus_a.score, bus_a.round_num, bus_a.round_active); end
      reset = 1'b0;
      base = ts_count;
      repeat (20) step();
      checks++; if (ts_count != base || bus_a.round_num !== 4'd0) begin errors++;
         $display("FAIL idle_after_mid_reset: got pulses %0d round %0d expected 0 0",
                  ts_count - base, bus_a.round_num); end
   endtask

   task automatic test_saturation();
      int ea;
      int eb;
      btn_start = 1'b1;
      step();
      btn_start = 1'b0;
      exp_score_a = 0;
      exp_score_b = 0;
      for (int r = 0; r < int'(NumRounds); r++) begin
         step();
         drive_answer(1'b1, 15, 1'b0);
         step();
         ea = q_a.pop_front();
         eb = q_b.pop_front();
         checks++; if (bus_a.score !== 8'(ea)) begin errors++;
            $display("FAIL wide_score_r%0d: got %0d expected %0d", r, bus_a.score, ea); end
         checks++; if (bus_b.score !== 2'(eb)) begin errors++;
            $display("FAIL sat_score_r%0d: got %0d expected %0d", r, bus_b.score, eb); end
         step();
      end
      checks++; if (bus_b.game_over !== 1'b1 || bus_b.score !== 2'd3) begin errors++;
         $display("FAIL sat_final: got over %0b score %0d expected 1 3",
                  bus_b.game_over, bus_b.score); end
   endtask

   initial begin
      test_reset();
      test_start_hold();
      test_fast_answer();
      test_slow_and_wrong();
      test_game_over();
      test_timeout();
      test_same_cycle();
      test_reset_mid_play();
      test_saturation();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule
